// File: rtl/async_req_arbiter_pkg.sv
// Shared types and helpers for the asynchronous-request arbiter family.
// rr_pick is written for up to MaxReq requesters so other arbiters can reuse it.
package async_req_arbiter_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    localparam int unsigned MaxReq = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // First set bit of req searching upward from (last+1) mod n, with wrap.
    // Returns last when no bit is set.
    function automatic logic [3:0] rr_pick(input logic [MaxReq-1:0] req,
                                           input logic [3:0]        last,
                                           input int unsigned       n);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned off = 1; off <= MaxReq; off++) begin
            idx = 5'({1'b0, last}) + 5'(off);
            if (32'(idx) >= n) idx = idx - 5'(n);
            if (!found && off <= n && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/async_req_arbiter_sync.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic async_reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter granting one multi-cycle shared resource to N_REQ
// requesters that use 4-phase req/ack handshakes from another clock domain.
module async_req_arbiter
    import async_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned IDX_W          = clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [N_REQ-1:0] req_async,
    output logic [N_REQ-1:0] ack,
    output logic             res_start,
    output logic [IDX_W-1:0] res_sel,
    input  logic             res_done,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_sticky,
    input  logic             err_clr
);

    logic [N_REQ-1:0] req_sync;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        sync_2ff u_sync (
            .clk         (clk),
            .async_reset (async_reset),
            .d           (req_async[i]),
            .q           (req_sync[i])
        );
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             err_to_q, err_to_d;
    logic             err_sticky_q, err_sticky_d;

    logic [IDX_W-1:0] winner;
    logic             timeout_hit;

    assign winner      = IDX_W'(rr_pick(MaxReq'(req_sync), 4'(last_q), N_REQ));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            last_q       <= IDX_W'(N_REQ - 1);
            cnt_q        <= '0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_to_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            err_to_q     <= err_to_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req_sync) begin
                    state_d = StBusy;
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the timeout cycle still counts as done.
                if (res_done || timeout_hit) state_d = StAck;
            end
            StAck: begin
                if (!req_sync[sel_q]) begin
                    state_d = StIdle;
                    last_d  = sel_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they leave a flop in step with it.
    always_comb begin
        ack_d = '0;
        if (state_d == StAck) ack_d[sel_d] = 1'b1;
        start_d      = (state_q == StIdle) && (state_d == StBusy);
        busy_d       = (state_d != StIdle);
        err_to_d     = (state_q == StBusy) && !res_done && timeout_hit;
        err_sticky_d = err_to_d | (err_sticky_q & ~err_clr);
    end

    assign ack         = ack_q;
    assign res_start   = start_q;
    assign res_sel     = sel_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed self-checking bench for async_req_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
module tb_async_req_arbiter;

    logic       clk;
    logic       async_reset;
    logic [3:0] req_async;
    logic [3:0] ack;
    logic       res_start;
    logic [1:0] res_sel;
    logic       res_done;
    logic       busy;
    logic       err_timeout;
    logic       err_sticky;
    logic       err_clr;

    int   checks;
    int   errors;
    logic multi_hot;

    async_req_arbiter #(
        .N_REQ          (4),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .req_async   (req_async),
        .ack         (ack),
        .res_start   (res_start),
        .res_sel     (res_sel),
        .res_done    (res_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!$onehot0(ack)) multi_hot = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (res_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " res_start"}, 32'(res_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    // Complete one transaction for requester exp; during ACK the other request
    // lines become nxt, and the winner re-raises its line only if nxt has it set.
    task automatic do_grant(input int exp, input logic [3:0] nxt, input string tag);
        int         n;
        logic [3:0] oh;
        oh = 4'b0001 << exp;
        wait_start(tag);
        check({tag, " sel"}, 32'(res_sel), 32'(exp));
        @(negedge clk);
        @(negedge clk);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        n = 0;
        while (ack == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ack"}, 32'(ack), 32'(oh));
        req_async = nxt & ~oh;
        n = 0;
        while (ack != 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ack drop"}, 32'(ack), 32'd0);
        req_async = nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        multi_hot   = 1'b0;
        async_reset = 1'b1;
        req_async   = '0;
        res_done    = 1'b0;
        err_clr     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ack", 32'(ack), 32'd0);
        check("rst start", 32'(res_start), 32'd0);
        check("rst sel", 32'(res_sel), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", {err_timeout, err_sticky}, 32'd0);
        async_reset = 1'b0;

        // Single request on line 2 with exact latencies.
        @(negedge clk);
        req_async = 4'b0100;
        @(negedge clk);
        check("s1 start e1", 32'(res_start), 32'd0);
        @(negedge clk);
        check("s1 start e2", 32'(res_start), 32'd0);
        @(negedge clk);
        check("s1 start e3", 32'(res_start), 32'd1);
        check("s1 sel", 32'(res_sel), 32'd2);
        check("s1 busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("s1 start pulse", 32'(res_start), 32'd0);
        @(negedge clk);
        check("s1 ack early", 32'(ack), 32'd0);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        check("s1 ack", 32'(ack), 32'h4);
        check("s1 busy ack", 32'(busy), 32'd1);
        req_async = 4'b0000;
        @(negedge clk);
        check("s1 ack hold1", 32'(ack), 32'h4);
        @(negedge clk);
        check("s1 ack hold2", 32'(ack), 32'h4);
        @(negedge clk);
        check("s1 ack fall", 32'(ack), 32'd0);
        check("s1 busy fall", 32'(busy), 32'd0);

        // Round robin from reset pointer, then wrap and fairness skip.
        async_reset = 1'b1;
        @(negedge clk);
        async_reset = 1'b0;
        req_async = 4'b1111;
        do_grant(0, 4'b1111, "rr0");
        do_grant(1, 4'b1111, "rr1");
        do_grant(2, 4'b1111, "rr2");
        do_grant(3, 4'b1111, "rr3");
        do_grant(0, 4'b0010, "rr4");
        do_grant(1, 4'b0000, "set last1");
        repeat (4) @(negedge clk);
        req_async = 4'b0011;
        do_grant(0, 4'b0011, "wrap0");
        do_grant(1, 4'b0000, "wrap1");

        // Timeout with no res_done.
        repeat (2) @(negedge clk);
        req_async = 4'b0100;
        wait_start("to");
        check("to sel", 32'(res_sel), 32'd2);
        n = 0;
        while (ack == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to busy cycles", 32'(n), 32'd8);
        check("to ack", 32'(ack), 32'h4);
        check("to pulse", 32'(err_timeout), 32'd1);
        check("to sticky", 32'(err_sticky), 32'd1);
        req_async = 4'b0000;
        @(negedge clk);
        check("to pulse end", 32'(err_timeout), 32'd0);
        check("to sticky hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to clr", 32'(err_sticky), 32'd0);
        wait_idle("to");

        // res_done on the final BUSY cycle wins over timeout.
        req_async = 4'b1000;
        wait_start("col");
        repeat (7) @(negedge clk);
        check("col ack early", 32'(ack), 32'd0);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        check("col ack", 32'(ack), 32'h8);
        check("col no err", {err_timeout, err_sticky}, 32'd0);
        req_async = 4'b0000;
        wait_idle("col");

        // Asynchronous reset in the middle of BUSY, then re-arbitration.
        req_async = 4'b1000;
        wait_start("mid");
        @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        #2 async_reset = 1'b1;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst sel", 32'(res_sel), 32'd0);
        check("mid rst ack", {res_start, ack}, 32'd0);
        @(negedge clk);
        async_reset = 1'b0;
        do_grant(3, 4'b0000, "rearb");

        check("ack onehot0", 32'(multi_hot), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
